logic_unit_seq: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the ALU datapath. It is the generalised successor of the fixed 32-bit single-function gate arrays. It accepts two WIDTH-bit operands and a 2-bit op code through a valid/ready handshake, then processes the operands CHUNK bits per cycle. The result is held with a zero flag until the consumer accepts it. Trading latency against gate count lets narrow-area builds share one CHUNK-wide gate slice.

---
 rtl/logic_unit_seq_if.sv | 26 ++
 rtl/logic_unit_seq.sv | 151 +++++++++++++++
 tb/tb_logic_unit_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/logic_unit_seq_if.sv
// Handshake bundle for logic_unit_seq: operand request channel, result channel and status.
// The slave modport is the unit itself; the master modport is the producer/consumer side.
interface logic_unit_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, result, zero, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, result, zero, busy
   );
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: latches two WIDTH-bit operands and an op code, then
// computes the result CHUNK bits per cycle (LSB slice first) and holds it until taken.
module logic_unit_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic              clock,
   input logic              reset,
   logic_unit_seq_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
         $error("logic_unit_seq: WIDTH must be an integer multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] result_r;
   logic             zero_r;

   logic             last_s;
   logic [IW-1:0]    base_s;
   logic [CHUNK-1:0] slice_s;
   logic [WIDTH-1:0] result_nxt_s;
   logic             in_ready_s;
   logic             busy_s;
   logic             out_valid_s;

   function automatic logic [CHUNK-1:0] apply_op(input logic [1:0]       op,
                                                 input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         2'b11:   return ~(a | b);
         default: return {CHUNK{1'b0}};
      endcase
   endfunction

   // Current slice computation and the result as it will look after this slice is written
   always_comb begin
      last_s       = (cnt_r == CW'(NCHUNK - 1));
      base_s       = IW'(cnt_r) * IW'(CHUNK);
      slice_s      = apply_op(op_r, a_r[base_s +: CHUNK], b_r[base_s +: CHUNK]);
      result_nxt_s = result_r;
      result_nxt_s[base_s +: CHUNK] = slice_s;
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; the DONE->IDLE edge never accepts, enforcing the issue gap
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) state_nxt_s = ST_BUSY;
            else              state_nxt_s = ST_IDLE;
         end
         ST_BUSY: begin
            if (last_s) state_nxt_s = ST_DONE;
            else        state_nxt_s = ST_BUSY;
         end
         ST_DONE: begin
            if (bus.out_ready) state_nxt_s = ST_IDLE;
            else               state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Status outputs decoded purely from the state register
   always_comb begin
      in_ready_s  = 1'b0;
      busy_s      = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         ST_IDLE: in_ready_s  = 1'b1;
         ST_BUSY: busy_s      = 1'b1;
         ST_DONE: out_valid_s = 1'b1;
         default: in_ready_s  = 1'b0;
      endcase
   end

   // Operand capture, slice-by-slice result build and zero flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_r    <= {CW{1'b0}};
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         op_r     <= 2'b00;
         result_r <= {WIDTH{1'b0}};
         zero_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  a_r      <= bus.in_a;
                  b_r      <= bus.in_b;
                  op_r     <= bus.in_op;
                  result_r <= {WIDTH{1'b0}};
                  cnt_r    <= {CW{1'b0}};
                  zero_r   <= 1'b0;
               end
            end
            ST_BUSY: begin
               result_r <= result_nxt_s;
               if (last_s) begin
                  zero_r <= (result_nxt_s == {WIDTH{1'b0}});
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_DONE: begin
               result_r <= result_r;
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.busy      = busy_s;
   assign bus.out_valid = out_valid_s;
   assign bus.result    = result_r;
   assign bus.zero      = zero_r;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: three configurations (32/8, 32/32, 16/4) driven in lock-step
// from one stimulus stream and compared against a bitwise reference model.
module tb_logic_unit_seq;
   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [1:0]  in_op;

   int n_cmp = 0;
   int n_err = 0;

   logic_unit_seq_if #(.WIDTH(32)) bus0 ();
   logic_unit_seq_if #(.WIDTH(32)) bus1 ();
   logic_unit_seq_if #(.WIDTH(16)) bus2 ();

   logic_unit_seq #(.WIDTH(32), .CHUNK(8))  dut0 (.clock(clock), .reset(reset), .bus(bus0));
   logic_unit_seq #(.WIDTH(32), .CHUNK(32)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
   logic_unit_seq #(.WIDTH(16), .CHUNK(4))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

   assign bus0.in_valid = in_valid;  assign bus0.out_ready = out_ready;
   assign bus0.in_a = in_a;          assign bus0.in_b = in_b;          assign bus0.in_op = in_op;
   assign bus1.in_valid = in_valid;  assign bus1.out_ready = out_ready;
   assign bus1.in_a = in_a;          assign bus1.in_b = in_b;          assign bus1.in_op = in_op;
   assign bus2.in_valid = in_valid;  assign bus2.out_ready = out_ready;
   assign bus2.in_a = in_a[15:0];    assign bus2.in_b = in_b[15:0];    assign bus2.in_op = in_op;

   logic [31:0] res [3];
   logic        ov [3];
   logic        ir [3];
   logic        bz [3];
   logic        zr [3];
   assign res[0] = bus0.result;  assign ov[0] = bus0.out_valid;  assign ir[0] = bus0.in_ready;
   assign bz[0]  = bus0.busy;    assign zr[0] = bus0.zero;
   assign res[1] = bus1.result;  assign ov[1] = bus1.out_valid;  assign ir[1] = bus1.in_ready;
   assign bz[1]  = bus1.busy;    assign zr[1] = bus1.zero;
   assign res[2] = {16'h0000, bus2.result};  assign ov[2] = bus2.out_valid;
   assign ir[2]  = bus2.in_ready; assign bz[2] = bus2.busy;  assign zr[2] = bus2.zero;

   int nch [3] = '{4, 1, 4};
   int chk [3] = '{8, 32, 4};
   int wid [3] = '{32, 32, 16};

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   function automatic logic [31:0] exp_for(input int d, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = ref_op(op, a, b);
      if (wid[d] == 16) r = r & 32'h0000_FFFF;
      return r;
   endfunction

   // Result visible after only the lowest 'bits' bits have been produced
   function automatic logic [31:0] partial(input logic [31:0] full, input int bits);
      if (bits >= 32) return full;
      return full & ((32'd1 << bits) - 32'd1);
   endfunction

   function automatic logic [31:0] b2w(input logic v);
      return {31'd0, v};
   endfunction

   // One full transaction on all three units; assumes the caller sits just after a negedge
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit perturb);
      logic [31:0] ex [3];
      for (int d = 0; d < 3; d++) begin
         ex[d] = exp_for(d, op, a, b);
         check_eq($sformatf("d%0d idle_ready", d), b2w(ir[d]), 32'd1);
      end
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; out_ready = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("d%0d j%0d out_valid", d, j), b2w(ov[d]), b2w(j >= nch[d]));
            check_eq($sformatf("d%0d j%0d busy", d, j), b2w(bz[d]), b2w(j < nch[d]));
            check_eq($sformatf("d%0d j%0d in_ready", d, j), b2w(ir[d]), 32'd0);
            check_eq($sformatf("d%0d j%0d partial", d, j), res[d], partial(ex[d], j * chk[d]));
         end
         if (perturb) begin
            in_a = 32'hFFFF_FFFF; in_b = $urandom; in_op = 2'd0; in_valid = 1'b1;
         end
         @(negedge clock);
      end
      for (int h = 0; h <= hold; h++) begin
         for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("d%0d h%0d done_valid", d, h), b2w(ov[d]), 32'd1);
            check_eq($sformatf("d%0d h%0d done_ready", d, h), b2w(ir[d]), 32'd0);
            check_eq($sformatf("d%0d h%0d done_busy", d, h), b2w(bz[d]), 32'd0);
            check_eq($sformatf("d%0d h%0d result", d, h), res[d], ex[d]);
            check_eq($sformatf("d%0d h%0d zero", d, h), b2w(zr[d]), b2w(ex[d] == 32'd0));
         end
         in_valid = 1'b1;
         if (h < hold) @(negedge clock);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("d%0d release_valid", d), b2w(ov[d]), 32'd0);
         check_eq($sformatf("d%0d release_ready", d), b2w(ir[d]), 32'd1);
         check_eq($sformatf("d%0d release_busy", d), b2w(bz[d]), 32'd0);
         check_eq($sformatf("d%0d idle_hold", d), res[d], ex[d]);
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 32'd0; in_b = 32'd0; in_op = 2'd0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("d%0d rst_ready", d), b2w(ir[d]), 32'd1);
         check_eq($sformatf("d%0d rst_valid", d), b2w(ov[d]), 32'd0);
         check_eq($sformatf("d%0d rst_busy", d), b2w(bz[d]), 32'd0);
         check_eq($sformatf("d%0d rst_result", d), res[d], 32'd0);
         check_eq($sformatf("d%0d rst_zero", d), b2w(zr[d]), 32'd0);
      end
      @(negedge clock);
      reset = 1'b0;

      run_op(2'd1, 32'hF0F0_0000, 32'h0000_0F0F, 0, 1'b0);
      run_op(2'd0, 32'h1234_5678, 32'h0F0F_0F0F, 0, 1'b0);
      run_op(2'd2, 32'hFFFF_0000, 32'hFF00_FF00, 0, 1'b0);
      run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);
      run_op(2'd1, 32'h1357_9BDF, 32'h0246_8ACE, 10, 1'b0);
      run_op(2'd1, 32'h0000_00FF, 32'h0000_0000, 0, 1'b1);
      run_op(2'd3, 32'h0000_00F0, 32'h0000_0F00, 1, 1'b0);

      // Asynchronous reset two cycles into an operation
      in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_op = 2'd2;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("d%0d midrst_valid", d), b2w(ov[d]), 32'd0);
         check_eq($sformatf("d%0d midrst_ready", d), b2w(ir[d]), 32'd1);
         check_eq($sformatf("d%0d midrst_busy", d), b2w(bz[d]), 32'd0);
         check_eq($sformatf("d%0d midrst_result", d), res[d], 32'd0);
      end
      @(negedge clock);
      reset = 1'b0;
      run_op(2'd2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(0, 3)), $urandom, $urandom,
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
